mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Shares the core's single 64-bit AHB-lite memory port between instruction fetch (IF) and the data-memory stage (MEM). Each requester issues a request and holds it until a one-cycle ready pulse returns read data. The arbiter sequences non-overlapped address and data phases on the bus and produces per-requester stall signals for the pipeline. It sits between the fetch and load/store units and the bus fabric.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, bus data width
- CLK  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-low; clock CLK
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch read data, valid with if_ready
- if_ready  out  1  one-cycle completion pulse to fetch
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_size  in  3  HSIZE encoding of the access
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid with d_ready
- d_ready  out  1  one-cycle completion pulse to MEM
- stall_if  out  1  fetch must hold PC
- stall_mem  out  1  MEM stage must hold
- HADDR  out  ADDR_W  bus address
- HTRANS  out  1  1 = active transfer
- HWRITE  out  1  bus write
- HSIZE  out  3  bus size; fetch always 3'b010
- HWDATA  out  DATA_W  bus write data
- HRDATA  in  DATA_W  bus read data
- HREADY  in  1  slave ready

## Operation
- States: IDLE, ADDR, DATA, RESP.
- IDLE: if any request is present, choose an owner, latch its addr, we, size and wdata, and go to ADDR. With no request, stay in IDLE with HTRANS=0.
- Priority: d_req beats if_req when both are present. Fetch transfers are always reads.
- ADDR: drive the latched HADDR, HWRITE and HSIZE with HTRANS=1. On an edge with HREADY=1, go to DATA. With HREADY=0, hold every output.
- DATA: HTRANS=0 and HWDATA = latched wdata. On an edge with HREADY=1, capture HRDATA into the owner's rdata register and go to RESP. With HREADY=0, hold.
- RESP: assert the owner's ready for exactly this cycle, then go to IDLE.
- A request still high in the following IDLE cycle counts as a new request.
- If a requester drops its req mid-transfer, the transfer still completes and the ready pulse is still issued.
- Stalls (combinational): stall_if = if_req & ~if_ready; stall_mem = d_req & ~d_ready.
- The rdata registers hold their last value until the next completion for the same requester.
- Reset values: state IDLE, HTRANS 0, HADDR 0, HWRITE 0, HSIZE 0, HWDATA 0, both rdata 0, both ready 0, owner = fetch.

## Timing
- Minimum latency is 4 cycles, counting from the req sample edge to the end of the ready cycle: IDLE -> ADDR -> DATA -> RESP.
- Each HREADY=0 cycle in ADDR or DATA adds one cycle.
- Throughput is at most one transfer per 4 cycles. There is no pipelining of the address and data phases.
- Assertion of reset at any point forces IDLE and HTRANS=0 immediately. The in-flight transfer is abandoned and no ready pulse is issued.
- if_ready and d_ready are never high in the same cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined: keep a last-owner bit. On simultaneous requests in IDLE, grant the requester that did not own the previous transfer.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, data always wins. Fetch may starve while d_req is held continuously; this is accepted, because the pipeline is stalled on MEM anyway.

## Structure
- Shared package a216_bus_pkg holds:
  - state encoding (IDLE/ADDR/DATA/RESP)
  - HTRANS idle/active constants
  - HSIZE_WORD = 3'b010
  - owner encoding OWN_IF / OWN_D
- Sub-module arb_priority: 2-requester grant picker with inputs req[1:0] and last_owner, and a one-hot grant output. The fixed or round-robin variant is selected by ARB_ROUND_ROBIN_EN.

## Test plan
- Fetch only: if_req=1, if_addr=0x100, HREADY=1, HRDATA=0x0000_0013 -> HADDR=0x100, HTRANS=1 for one cycle; if_ready on the 4th cycle with if_rdata=0x13; stall_if=1 until then.
- Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEAD_BEEF -> HWRITE=1, HSIZE=d_size in ADDR; HWDATA=0xDEADBEEF in DATA; d_ready pulses once.
- Contention, macro undefined: if_req and d_req both held -> three consecutive data transfers with no fetch grant. Macro defined: grants alternate D, IF, D.
- Wait states: HREADY=0 for 2 cycles in DATA -> HWDATA and HADDR stable; ready arrives at cycle 6.
- Reset mid-transfer: reset low during DATA -> HTRANS=0 and state IDLE at once; no ready pulse. After release, a held request restarts from ADDR.

Source files
------------

// File: rtl/a216_bus_pkg.sv
// Shared encodings for the core's memory-port arbiter: FSM states, AHB constants, owner ids.
// Latency: n/a (constants only).
// Backpressure: n/a.
package a216_bus_pkg;

    // Arbiter FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Single-bit HTRANS view used by this port (IDLE vs NONSEQ)
    localparam logic HTRANS_IDLE   = 1'b0;
    localparam logic HTRANS_ACTIVE = 1'b1;

    // Instruction fetches are always 32-bit words
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Owner of the current / most recent transfer
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Bit positions in the request / grant vectors
    localparam int REQ_IF_BIT = 0;
    localparam int REQ_D_BIT  = 1;

endpackage

// File: rtl/mem_bus_arbiter_arb_priority.sv
// Two-requester grant picker (bit 0 = fetch, bit 1 = data), one-hot grant.
// Latency: combinational. Build macro: ARB_ROUND_ROBIN_EN selects alternating grants on contention.
// Backpressure: none here; the caller only samples the grant while idle.
module arb_priority
    import a216_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] grant
);

`ifdef ARB_ROUND_ROBIN_EN
    // On contention grant whoever did not own the previous transfer; otherwise pass the lone request
    always_comb begin
        grant = 2'b00;
        if (req[REQ_D_BIT] && req[REQ_IF_BIT]) begin
            grant[REQ_D_BIT]  = (last_owner == OWN_IF);
            grant[REQ_IF_BIT] = (last_owner == OWN_D);
        end else begin
            grant = req;
        end
    end
`else
    // Fixed priority ignores history; data always wins because the pipeline is stalled on MEM anyway
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    // Data request beats fetch request
    always_comb begin
        grant = 2'b00;
        if (req[REQ_D_BIT]) begin
            grant[REQ_D_BIT] = 1'b1;
        end else if (req[REQ_IF_BIT]) begin
            grant[REQ_IF_BIT] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one AHB-lite port between fetch and MEM with non-overlapped address/data phases.
// Latency: 4 cycles min (IDLE, ADDR, DATA, RESP); +1 per HREADY=0 cycle. Build macro: ARB_ROUND_ROBIN_EN.
// Backpressure: requesters hold req until their ready pulse; HREADY=0 freezes ADDR/DATA phases.
module mem_bus_arbiter
    import a216_bus_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
)(
    input  logic              CLK,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY
);

    // Everything the bus needs for one transfer, captured at grant time
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [2:0]        size;
        logic [DATA_W-1:0] wdata;
    } xfer_t;

    logic [1:0]        state_q;
    logic              owner_q;
    xfer_t             xfer_q;
    xfer_t             xfer_sel;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic [1:0]        req_vec;
    logic [1:0]        grant;
    logic              granted;

    assign req_vec = {d_req, if_req};
    assign granted = |grant;

    arb_priority u_arb (
        .req        (req_vec),
        .last_owner (owner_q),
        .grant      (grant)
    );

    // Pick the winning requester's transfer attributes; fetches are word reads with no write data
    always_comb begin
        xfer_sel.addr  = if_addr;
        xfer_sel.we    = 1'b0;
        xfer_sel.size  = HSIZE_WORD;
        xfer_sel.wdata = '0;
        if (grant[REQ_D_BIT]) begin
            xfer_sel.addr  = d_addr;
            xfer_sel.we    = d_we;
            xfer_sel.size  = d_size;
            xfer_sel.wdata = d_wdata;
        end
    end

    // Phase sequencing: one transfer at a time, HREADY stretches ADDR and DATA
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (granted) state_q <= ST_ADDR;
                ST_ADDR: if (HREADY)  state_q <= ST_DATA;
                ST_DATA: if (HREADY)  state_q <= ST_RESP;
                ST_RESP:              state_q <= ST_IDLE;
                default:              state_q <= ST_IDLE;
            endcase
        end
    end

    // Latch owner and transfer attributes at grant; owner doubles as the round-robin history bit
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            owner_q <= OWN_IF;
            xfer_q  <= '0;
        end else if (state_q == ST_IDLE && granted) begin
            owner_q <= grant[REQ_D_BIT] ? OWN_D : OWN_IF;
            xfer_q  <= xfer_sel;
        end
    end

    // Capture read data for the owner at the end of the data phase; the other register keeps its value
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (state_q == ST_DATA && HREADY) begin
            if (owner_q == OWN_D) begin
                d_rdata_q <= HRDATA;
            end else begin
                if_rdata_q <= HRDATA;
            end
        end
    end

    assign HTRANS = (state_q == ST_ADDR) ? HTRANS_ACTIVE : HTRANS_IDLE;
    assign HADDR  = xfer_q.addr;
    assign HWRITE = xfer_q.we;
    assign HSIZE  = xfer_q.size;
    assign HWDATA = xfer_q.wdata;

    // Ready pulses come straight from the RESP state, so only the owner can see one
    assign if_ready = (state_q == ST_RESP) && (owner_q == OWN_IF);
    assign d_ready  = (state_q == ST_RESP) && (owner_q == OWN_D);
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = d_req & ~d_ready;

endmodule
